// File: rtl/bellek_hakemi.sv
// bellek_hakemi: arbiter for the single main-memory (QSPI-backed) port.
// It shares the port between the L1 instruction-cache refill (l1b) and the
// L1 data cache (l1v), with one outstanding transaction at a time.
// It captures the request, routes the response back to its owner and aborts
// a stuck transaction with a watchdog.
// Build option: define ADIL_HAKEM_EN for round-robin arbitration. Without it,
// l1v has fixed priority on a collision.
module bellek_hakemi #(
    parameter int unsigned ADRES_BIT   = 32,
    parameter int unsigned VERI_BIT    = 32,
    parameter int unsigned ZAMAN_ASIMI = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   l1b_istek_i,
    input  logic [ADRES_BIT-1:2]   l1b_adr_i,
    output logic                   l1b_hazir_o,
    output logic                   l1b_gecerli_o,
    output logic [VERI_BIT-1:0]    l1b_veri_o,

    input  logic                   l1v_istek_i,
    input  logic                   l1v_yaz_i,
    input  logic [ADRES_BIT-1:2]   l1v_adr_i,
    input  logic [VERI_BIT-1:0]    l1v_veri_i,
    input  logic [VERI_BIT/8-1:0]  l1v_maske_i,
    output logic                   l1v_hazir_o,
    output logic                   l1v_gecerli_o,
    output logic [VERI_BIT-1:0]    l1v_veri_o,

    output logic                   bel_istek_o,
    output logic                   bel_yaz_o,
    output logic [ADRES_BIT-1:2]   bel_adr_o,
    output logic [VERI_BIT-1:0]    bel_veri_o,
    output logic [VERI_BIT/8-1:0]  bel_maske_o,
    input  logic                   bel_hazir_i,
    input  logic                   bel_gecerli_i,
    input  logic [VERI_BIT-1:0]    bel_veri_i,

    output logic                   hata_o
);

    localparam int unsigned SAYAC_BIT = $clog2(ZAMAN_ASIMI);

    localparam logic [1:0] BOSTA = 2'd0;
    localparam logic [1:0] ISTEK = 2'd1;
    localparam logic [1:0] YANIT = 2'd2;

    localparam logic SAHIP_L1B = 1'b0;
    localparam logic SAHIP_L1V = 1'b1;

    logic [1:0]           durum;
    logic [1:0]           durum_sonraki;
    logic                 sahip;
    logic [SAYAC_BIT-1:0] sayac;
    logic                 sure_doldu;
    logic                 l1b_oncelik;
    logic                 l1b_sec;
    logic                 l1v_sec;
    logic                 yanit_olay;
    logic                 asim_olay;
    logic                 bitir;

    // The owner register also holds the last owner. Round-robin reads it to break a collision.
`ifdef ADIL_HAKEM_EN
    assign l1b_oncelik = (sahip == SAHIP_L1V);
`else
    assign l1b_oncelik = 1'b0;
`endif

    assign sure_doldu  = (sayac == SAYAC_BIT'(ZAMAN_ASIMI - 1));
    assign bitir       = yanit_olay | asim_olay;
    assign l1b_hazir_o = l1b_sec;
    assign l1v_hazir_o = l1v_sec;
    assign bel_istek_o = (durum == ISTEK);

    // Next state, grant and completion events
    always_comb begin
        durum_sonraki = durum;
        l1b_sec       = 1'b0;
        l1v_sec       = 1'b0;
        yanit_olay    = 1'b0;
        asim_olay     = 1'b0;
        case (durum)
            BOSTA: begin
                // Gate the grant with reset so that no accept pulse leaks out while reset is held.
                l1b_sec = rst_i & l1b_istek_i & (~l1v_istek_i | l1b_oncelik);
                l1v_sec = rst_i & l1v_istek_i & ~l1b_sec;
                if (l1b_sec || l1v_sec) begin
                    durum_sonraki = ISTEK;
                end
            end
            ISTEK: begin
                if (bel_hazir_i && bel_gecerli_i) begin
                    yanit_olay = 1'b1;
                end else if (sure_doldu) begin
                    asim_olay = 1'b1;
                end else if (bel_hazir_i) begin
                    durum_sonraki = YANIT;
                end
            end
            YANIT: begin
                if (bel_gecerli_i) begin
                    yanit_olay = 1'b1;
                end else if (sure_doldu) begin
                    asim_olay = 1'b1;
                end
            end
            default: begin
                durum_sonraki = BOSTA;
            end
        endcase
        if (bitir) begin
            durum_sonraki = BOSTA;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum <= BOSTA;
        end else begin
            durum <= durum_sonraki;
        end
    end

    // Capture the granted request fields and its owner
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sahip       <= SAHIP_L1B;
            bel_yaz_o   <= 1'b0;
            bel_adr_o   <= '0;
            bel_veri_o  <= '0;
            bel_maske_o <= '0;
        end else if (l1v_sec) begin
            sahip       <= SAHIP_L1V;
            bel_yaz_o   <= l1v_yaz_i;
            bel_adr_o   <= l1v_adr_i;
            bel_veri_o  <= l1v_veri_i;
            bel_maske_o <= l1v_maske_i;
        end else if (l1b_sec) begin
            sahip       <= SAHIP_L1B;
            bel_yaz_o   <= 1'b0;
            bel_adr_o   <= l1b_adr_i;
            bel_veri_o  <= '0;
            bel_maske_o <= '0;
        end
    end

    // Watchdog: cleared at grant, counts every cycle a transaction is open
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sayac <= '0;
        end else if (l1b_sec || l1v_sec) begin
            sayac <= '0;
        end else if (durum != BOSTA) begin
            sayac <= sayac + SAYAC_BIT'(1);
        end
    end

    // Route the completion (response or timeout abort) back to its owner as a one-cycle pulse
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            l1b_gecerli_o <= 1'b0;
            l1v_gecerli_o <= 1'b0;
            l1b_veri_o    <= '0;
            l1v_veri_o    <= '0;
            hata_o        <= 1'b0;
        end else begin
            l1b_gecerli_o <= bitir & (sahip == SAHIP_L1B);
            l1v_gecerli_o <= bitir & (sahip == SAHIP_L1V);
            hata_o        <= asim_olay;
            if (bitir && (sahip == SAHIP_L1B)) begin
                l1b_veri_o <= asim_olay ? '0 : bel_veri_i;
            end
            if (bitir && (sahip == SAHIP_L1V)) begin
                l1v_veri_o <= (asim_olay || bel_yaz_o) ? '0 : bel_veri_i;
            end
        end
    end

endmodule

// File: tb/tb_bellek_hakemi.sv
// Directed bench for bellek_hakemi with hand-computed expectations.
// Arbitration expectations follow ADIL_HAKEM_EN when it is defined.
module tb_bellek_hakemi;

`ifdef ADIL_HAKEM_EN
    localparam bit ADIL = 1'b1;
`else
    localparam bit ADIL = 1'b0;
`endif

    logic        clk_i;
    logic        rst_i;
    logic        l1b_istek_i;
    logic [29:0] l1b_adr_i;
    logic        l1b_hazir_o;
    logic        l1b_gecerli_o;
    logic [31:0] l1b_veri_o;
    logic        l1v_istek_i;
    logic        l1v_yaz_i;
    logic [29:0] l1v_adr_i;
    logic [31:0] l1v_veri_i;
    logic [3:0]  l1v_maske_i;
    logic        l1v_hazir_o;
    logic        l1v_gecerli_o;
    logic [31:0] l1v_veri_o;
    logic        bel_istek_o;
    logic        bel_yaz_o;
    logic [29:0] bel_adr_o;
    logic [31:0] bel_veri_o;
    logic [3:0]  bel_maske_o;
    logic        bel_hazir_i;
    logic        bel_gecerli_i;
    logic [31:0] bel_veri_i;
    logic        hata_o;

    int checks = 0;
    int errors = 0;

    bellek_hakemi #(.ADRES_BIT(32), .VERI_BIT(32), .ZAMAN_ASIMI(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .l1b_istek_i(l1b_istek_i), .l1b_adr_i(l1b_adr_i), .l1b_hazir_o(l1b_hazir_o),
        .l1b_gecerli_o(l1b_gecerli_o), .l1b_veri_o(l1b_veri_o),
        .l1v_istek_i(l1v_istek_i), .l1v_yaz_i(l1v_yaz_i), .l1v_adr_i(l1v_adr_i),
        .l1v_veri_i(l1v_veri_i), .l1v_maske_i(l1v_maske_i), .l1v_hazir_o(l1v_hazir_o),
        .l1v_gecerli_o(l1v_gecerli_o), .l1v_veri_o(l1v_veri_o),
        .bel_istek_o(bel_istek_o), .bel_yaz_o(bel_yaz_o), .bel_adr_o(bel_adr_o),
        .bel_veri_o(bel_veri_o), .bel_maske_o(bel_maske_o), .bel_hazir_i(bel_hazir_i),
        .bel_gecerli_i(bel_gecerli_i), .bel_veri_i(bel_veri_i), .hata_o(hata_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Drive point: just after the rising edge
    task automatic sonraki();
        @(posedge clk_i);
        #1;
    endtask

    // Sample point: falling edge
    task automatic ornek();
        @(negedge clk_i);
    endtask

    task automatic k1(input string ad, input logic gozlenen, input logic beklenen);
        checks++;
        assert (gozlenen === beklenen) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", ad, gozlenen, beklenen);
        end
    endtask

    task automatic k32(input string ad, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        checks++;
        assert (gozlenen === beklenen) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", ad, gozlenen, beklenen);
        end
    endtask

    task automatic hepsi_sifir(input string ad);
        k1({ad, "_l1b_hazir"}, l1b_hazir_o, 1'b0);
        k1({ad, "_l1v_hazir"}, l1v_hazir_o, 1'b0);
        k1({ad, "_l1b_gecerli"}, l1b_gecerli_o, 1'b0);
        k1({ad, "_l1v_gecerli"}, l1v_gecerli_o, 1'b0);
        k32({ad, "_l1b_veri"}, l1b_veri_o, 32'h0);
        k32({ad, "_l1v_veri"}, l1v_veri_o, 32'h0);
        k1({ad, "_bel_istek"}, bel_istek_o, 1'b0);
        k1({ad, "_bel_yaz"}, bel_yaz_o, 1'b0);
        k32({ad, "_bel_adr"}, 32'(bel_adr_o), 32'h0);
        k32({ad, "_bel_veri"}, bel_veri_o, 32'h0);
        k32({ad, "_bel_maske"}, 32'(bel_maske_o), 32'h0);
        k1({ad, "_hata"}, hata_o, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic exp_v;
        logic onceki_v;
        rst_i = 1'b0;
        l1b_istek_i = 1'b1; l1b_adr_i = 30'h0;
        l1v_istek_i = 1'b1; l1v_yaz_i = 1'b0; l1v_adr_i = 30'h0;
        l1v_veri_i = 32'h0; l1v_maske_i = 4'h0;
        bel_hazir_i = 1'b0; bel_gecerli_i = 1'b0; bel_veri_i = 32'h0;
        onceki_v = 1'b0;

        // Reset: requests held high must not be accepted
        sonraki(); sonraki();
        ornek();
        hepsi_sifir("reset");
        sonraki();
        rst_i = 1'b1; l1b_istek_i = 1'b0; l1v_istek_i = 1'b0;
        ornek();
        k1("idle_l1b_hazir", l1b_hazir_o, 1'b0);

        // 1: l1b read 0x100
        sonraki(); l1b_istek_i = 1'b1; l1b_adr_i = 30'h100;
        ornek();   k1("t1_l1b_hazir", l1b_hazir_o, 1'b1); k1("t1_l1v_hazir", l1v_hazir_o, 1'b0);
        sonraki(); l1b_istek_i = 1'b0; l1b_adr_i = 30'h3FF;
        ornek();   k1("t1_bel_istek", bel_istek_o, 1'b1); k32("t1_bel_adr", 32'(bel_adr_o), 32'h100);
                   k1("t1_bel_yaz", bel_yaz_o, 1'b0);
        sonraki(); bel_hazir_i = 1'b1;
        ornek();   k1("t1_bel_istek_held", bel_istek_o, 1'b1);
        sonraki(); bel_hazir_i = 1'b0;
        ornek();   k1("t1_bel_istek_drop", bel_istek_o, 1'b0);
        sonraki();
        sonraki(); bel_gecerli_i = 1'b1; bel_veri_i = 32'hDEADBEEF;
        ornek();   k1("t1_no_early_gecerli", l1b_gecerli_o, 1'b0);
        sonraki(); bel_gecerli_i = 1'b0; bel_veri_i = 32'h0;
        ornek();   k1("t1_l1b_gecerli", l1b_gecerli_o, 1'b1); k32("t1_l1b_veri", l1b_veri_o, 32'hDEADBEEF);
                   k1("t1_l1v_gecerli", l1v_gecerli_o, 1'b0); k1("t1_hata", hata_o, 1'b0);
        sonraki();
        ornek();   k1("t1_gecerli_pulse", l1b_gecerli_o, 1'b0);

        // 2: l1v write 0x40
        sonraki(); l1v_istek_i = 1'b1; l1v_yaz_i = 1'b1; l1v_adr_i = 30'h40;
                   l1v_veri_i = 32'h12345678; l1v_maske_i = 4'b0011;
        ornek();   k1("t2_l1v_hazir", l1v_hazir_o, 1'b1); k1("t2_l1b_hazir", l1b_hazir_o, 1'b0);
        sonraki(); l1v_istek_i = 1'b0; l1v_yaz_i = 1'b0; l1v_adr_i = 30'h0;
                   l1v_veri_i = 32'hFFFFFFFF; l1v_maske_i = 4'hF; bel_hazir_i = 1'b1;
        ornek();   k1("t2_bel_istek", bel_istek_o, 1'b1); k1("t2_bel_yaz", bel_yaz_o, 1'b1);
                   k32("t2_bel_adr", 32'(bel_adr_o), 32'h40); k32("t2_bel_veri", bel_veri_o, 32'h12345678);
                   k32("t2_bel_maske", 32'(bel_maske_o), 32'h3);
        sonraki(); bel_hazir_i = 1'b0;
        ornek();   k1("t2_bel_istek_drop", bel_istek_o, 1'b0);
        sonraki(); bel_gecerli_i = 1'b1; bel_veri_i = 32'hCAFEF00D;
        sonraki(); bel_gecerli_i = 1'b0; bel_veri_i = 32'h0;
        ornek();   k1("t2_l1v_gecerli", l1v_gecerli_o, 1'b1); k32("t2_l1v_veri", l1v_veri_o, 32'h0);
                   k1("t2_l1b_gecerli", l1b_gecerli_o, 1'b0);

        // 6: same-cycle accept and response, new grant in the delivery cycle
        sonraki(); l1b_istek_i = 1'b1; l1b_adr_i = 30'h200;
        ornek();   k1("t6_l1b_hazir", l1b_hazir_o, 1'b1);
        sonraki(); l1b_istek_i = 1'b0; bel_hazir_i = 1'b1; bel_gecerli_i = 1'b1; bel_veri_i = 32'h0BADF00D;
                   l1v_istek_i = 1'b1; l1v_yaz_i = 1'b0; l1v_adr_i = 30'h80;
        ornek();   k1("t6_bel_istek", bel_istek_o, 1'b1); k1("t6_l1v_wait", l1v_hazir_o, 1'b0);
        sonraki(); bel_hazir_i = 1'b0; bel_gecerli_i = 1'b0; bel_veri_i = 32'h0;
        ornek();   k1("t6_l1b_gecerli", l1b_gecerli_o, 1'b1); k32("t6_l1b_veri", l1b_veri_o, 32'h0BADF00D);
                   k1("t6_new_grant", l1v_hazir_o, 1'b1);
        sonraki(); l1v_istek_i = 1'b0; bel_hazir_i = 1'b1;
        ornek();   k32("t6_bel_adr", 32'(bel_adr_o), 32'h80); k1("t6_bel_yaz", bel_yaz_o, 1'b0);
        sonraki(); bel_hazir_i = 1'b0; bel_gecerli_i = 1'b1; bel_veri_i = 32'h55AA55AA;
        sonraki(); bel_gecerli_i = 1'b0; bel_veri_i = 32'h0;
        ornek();   k1("t6_l1v_gecerli", l1v_gecerli_o, 1'b1); k32("t6_l1v_veri", l1v_veri_o, 32'h55AA55AA);

        // 4: timeout after 8 cycles with no memory accept
        sonraki(); l1b_istek_i = 1'b1; l1b_adr_i = 30'h300;
        ornek();   k1("t4_l1b_hazir", l1b_hazir_o, 1'b1);
        sonraki(); l1b_istek_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            ornek();
            k1($sformatf("t4_bel_istek_c%0d", k), bel_istek_o, 1'b1);
            k1($sformatf("t4_no_gecerli_c%0d", k), l1b_gecerli_o, 1'b0);
            sonraki();
        end
        ornek();   k1("t4_bel_istek_drop", bel_istek_o, 1'b0); k1("t4_l1b_gecerli", l1b_gecerli_o, 1'b1);
                   k1("t4_hata", hata_o, 1'b1); k32("t4_l1b_veri", l1b_veri_o, 32'h0);
                   k1("t4_l1v_gecerli", l1v_gecerli_o, 1'b0);
        sonraki(); bel_gecerli_i = 1'b1; bel_veri_i = 32'h11111111;
        ornek();   k1("t4_hata_pulse", hata_o, 1'b0);
        sonraki(); bel_gecerli_i = 1'b0; bel_veri_i = 32'h0;
        ornek();   k1("t4_stray_l1b", l1b_gecerli_o, 1'b0); k1("t4_stray_l1v", l1v_gecerli_o, 1'b0);
        sonraki(); l1v_istek_i = 1'b1; l1v_yaz_i = 1'b0; l1v_adr_i = 30'h44;
        ornek();   k1("t4_next_hazir", l1v_hazir_o, 1'b1);
        sonraki(); l1v_istek_i = 1'b0; bel_hazir_i = 1'b1;
        sonraki(); bel_hazir_i = 1'b0; bel_gecerli_i = 1'b1; bel_veri_i = 32'h00000077;
        sonraki(); bel_gecerli_i = 1'b0; bel_veri_i = 32'h0;
        ornek();   k1("t4_next_gecerli", l1v_gecerli_o, 1'b1); k32("t4_next_veri", l1v_veri_o, 32'h77);
                   k1("t4_next_hata", hata_o, 1'b0);

        // 5: reset while waiting for the response
        sonraki(); l1b_istek_i = 1'b1; l1b_adr_i = 30'h123;
        ornek();   k1("t5_l1b_hazir", l1b_hazir_o, 1'b1);
        sonraki(); l1b_istek_i = 1'b0; bel_hazir_i = 1'b1;
        sonraki(); bel_hazir_i = 1'b0;
        ornek();   k1("t5_in_yanit", bel_istek_o, 1'b0); k32("t5_adr_before", 32'(bel_adr_o), 32'h123);
        rst_i = 1'b0;
        #1;
        hepsi_sifir("t5_async");
        sonraki(); rst_i = 1'b1; bel_gecerli_i = 1'b1; bel_veri_i = 32'h00000BAD;
        sonraki(); bel_gecerli_i = 1'b0; bel_veri_i = 32'h0;
        ornek();   k1("t5_stray_l1b", l1b_gecerli_o, 1'b0); k1("t5_stray_l1v", l1v_gecerli_o, 1'b0);
        sonraki(); l1b_istek_i = 1'b1; l1b_adr_i = 30'h124;
        ornek();   k1("t5_next_hazir", l1b_hazir_o, 1'b1);
        sonraki(); l1b_istek_i = 1'b0; bel_hazir_i = 1'b1;
        ornek();   k32("t5_next_adr", 32'(bel_adr_o), 32'h124);
        sonraki(); bel_hazir_i = 1'b0; bel_gecerli_i = 1'b1; bel_veri_i = 32'h0000A5A5;
        sonraki(); bel_gecerli_i = 1'b0; bel_veri_i = 32'h0;
        ornek();   k1("t5_next_gecerli", l1b_gecerli_o, 1'b1); k32("t5_next_veri", l1b_veri_o, 32'hA5A5);
                   k1("t5_next_hata", hata_o, 1'b0);

        // 3: both sides request continuously; last owner is l1b here
        sonraki(); l1b_istek_i = 1'b1; l1b_adr_i = 30'h500;
                   l1v_istek_i = 1'b1; l1v_yaz_i = 1'b0; l1v_adr_i = 30'h600;
        for (int t = 0; t < 4; t++) begin
            exp_v = ADIL ? ((t % 2) == 0) : 1'b1;
            ornek();
            if (t > 0) begin
                k1($sformatf("t3_l1v_gecerli_%0d", t - 1), l1v_gecerli_o, onceki_v);
                k1($sformatf("t3_l1b_gecerli_%0d", t - 1), l1b_gecerli_o, ~onceki_v);
            end
            k1($sformatf("t3_l1v_hazir_%0d", t), l1v_hazir_o, exp_v);
            k1($sformatf("t3_l1b_hazir_%0d", t), l1b_hazir_o, ~exp_v);
            onceki_v = exp_v;
            sonraki(); bel_hazir_i = 1'b1; bel_gecerli_i = 1'b1; bel_veri_i = 32'h1000 + 32'(t);
            ornek();   k1($sformatf("t3_bel_istek_%0d", t), bel_istek_o, 1'b1);
            sonraki(); bel_hazir_i = 1'b0; bel_gecerli_i = 1'b0; bel_veri_i = 32'h0;
            if (t == 3) begin
                l1b_istek_i = 1'b0; l1v_istek_i = 1'b0;
            end
        end
        ornek();
        k1("t3_l1v_gecerli_3", l1v_gecerli_o, onceki_v);
        k1("t3_l1b_gecerli_3", l1b_gecerli_o, ~onceki_v);
        k1("t3_no_more_l1v", l1v_hazir_o, 1'b0);
        k1("t3_no_more_l1b", l1b_hazir_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
